// File: rtl/gbp_update_sched.sv
// -----------------------------------------------------------------------------
// gbp_update_sched
//
// Sits in front of the global branch predictor update port.
//  - Round-robin arbitration of resolved-branch updates from NR_REQ requesters
//    into a DEPTH-entry in-order FIFO; the head drives the predictor port.
//  - Predictor flush is a row-by-row clear walk (one row per cycle over
//    NR_ROWS cycles). The FIFO is discarded when the flush starts.
//  - In debug mode, queued updates are popped and discarded instead of issued.
//
// Ports:
//  clk_i, rst_ni              clock, asynchronous active-low reset
//  flush_req_i                start / restart the clear walk
//  debug_mode_i               core is in debug mode (discard updates)
//  upd_valid_i/upd_ready_o    per-requester handshake (ready is one-hot or 0)
//  upd_pc_i/upd_taken_i       per-requester payload, requester i at [i*VLEN+:VLEN]
//  bht_upd_valid_o/_ready_i   predictor update handshake
//  bht_upd_pc_o/_taken_o      FIFO head payload
//  clr_valid_o/clr_row_o      row clear strobe and row index during the walk
//  busy_o                     clear walk in progress
//  drop_cnt_o                 saturating count of discarded updates
// -----------------------------------------------------------------------------
module gbp_update_sched #(
  parameter int unsigned VLEN     = 64,
  parameter int unsigned NR_REQ   = 2,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NR_ROWS  = 512,
  parameter int unsigned ROW_BITS = $clog2(NR_ROWS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_req_i,
  input  logic                     debug_mode_i,
  input  logic [NR_REQ-1:0]        upd_valid_i,
  output logic [NR_REQ-1:0]        upd_ready_o,
  input  logic [NR_REQ*VLEN-1:0]   upd_pc_i,
  input  logic [NR_REQ-1:0]        upd_taken_i,
  output logic                     bht_upd_valid_o,
  input  logic                     bht_upd_ready_i,
  output logic [VLEN-1:0]          bht_upd_pc_o,
  output logic                     bht_upd_taken_o,
  output logic                     clr_valid_o,
  output logic [ROW_BITS-1:0]      clr_row_o,
  output logic                     busy_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned RR_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_e;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } entry_t;

  state_e              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  entry_t              mem_q [DEPTH];
  entry_t              mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [15:0]         drop_q, drop_d;

  logic                run;
  logic                empty;
  logic                full;
  logic                found;
  logic [RR_W-1:0]     grant_idx;
  logic                push;
  logic                issue_pop;
  logic                dbg_pop;
  logic                pop;
  entry_t              push_entry;
  entry_t              head;
  logic [16:0]         drop_sum;

  assign run   = (state_q == ST_RUN);
  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // Round-robin search starting at rr_q; first asserted valid wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is never inferred.
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NR_REQ; k++) begin
      if (!found && upd_valid_i[(int'(rr_q) + k) % NR_REQ]) begin
        found     = 1'b1;
        grant_idx = RR_W'((int'(rr_q) + k) % NR_REQ);
      end
    end
  end

  // No full-bypass: a full FIFO refuses pushes even if it pops this cycle.
  // A flush request also blocks the push since the FIFO is being discarded.
  assign push = run && !flush_req_i && !full && found;

  always_comb begin
    upd_ready_o = '0;
    if (push) upd_ready_o[grant_idx] = 1'b1;
  end

  assign push_entry.pc    = upd_pc_i[grant_idx*VLEN +: VLEN];
  assign push_entry.taken = upd_taken_i[grant_idx];

  assign bht_upd_valid_o = run && !empty && !debug_mode_i;
  assign bht_upd_pc_o    = head.pc;
  assign bht_upd_taken_o = head.taken;
  assign issue_pop       = bht_upd_valid_o && bht_upd_ready_i;
  assign dbg_pop         = run && !empty && debug_mode_i;
  assign pop             = issue_pop || dbg_pop;

  assign clr_valid_o = (state_q == ST_FLUSH);
  assign busy_o      = (state_q == ST_FLUSH);
  assign clr_row_o   = row_q;
  assign drop_cnt_o  = drop_q;

  // FIFO, pointer and drop counter next state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_d     = rr_q;
    drop_sum = {1'b0, drop_q};

    if (flush_req_i) begin
      // Discard everything; keep the read pointer so the head output holds.
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
      drop_sum = drop_sum + 17'(count_q);
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        rr_d            = RR_W'((int'(grant_idx) + 1) % NR_REQ);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (dbg_pop) drop_sum = drop_sum + 17'd1;
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    drop_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Run / flush-walk state machine.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    unique case (state_q)
      ST_RUN: begin
        if (flush_req_i) begin
          state_d = ST_FLUSH;
          row_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_req_i) begin
          row_d = '0;
        end else if (row_q == ROW_BITS'(NR_ROWS - 1)) begin
          state_d = ST_RUN;
          row_d   = '0;
        end else begin
          row_d = row_q + ROW_BITS'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        row_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RUN;
      row_q    <= '0;
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      // NOTE: the FIFO storage is reset so the head outputs read 0 out of
      // reset; it is only DEPTH entries, so the reset fan-out is small.
      mem_q    <= '{default: '0};
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its _d value from before the edge.
      state_q  <= state_d;
      row_q    <= row_d;
      rr_q     <= rr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_gbp_update_sched.sv
// -----------------------------------------------------------------------------
// tb_gbp_update_sched
//
// Directed bench for gbp_update_sched (NR_REQ=2, DEPTH=4, NR_ROWS=8).
// Each step drives inputs just after a rising edge and compares on the
// falling edge against a small reference model: a scoreboard queue of
// expected predictor updates, a round-robin pointer, the flush walk state
// and the expected drop count.
// -----------------------------------------------------------------------------
module tb_gbp_update_sched;

  localparam int unsigned VLEN    = 64;
  localparam int unsigned NR_REQ  = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned NR_ROWS = 8;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } exp_t;

  logic                   clk_i;
  logic                   rst_ni;
  logic                   flush_req_i;
  logic                   debug_mode_i;
  logic [NR_REQ-1:0]      upd_valid_i;
  logic [NR_REQ-1:0]      upd_ready_o;
  logic [NR_REQ*VLEN-1:0] upd_pc_i;
  logic [NR_REQ-1:0]      upd_taken_i;
  logic                   bht_upd_valid_o;
  logic                   bht_upd_ready_i;
  logic [VLEN-1:0]        bht_upd_pc_o;
  logic                   bht_upd_taken_o;
  logic                   clr_valid_o;
  logic [2:0]             clr_row_o;
  logic                   busy_o;
  logic [15:0]            drop_cnt_o;

  gbp_update_sched #(
    .VLEN    (VLEN),
    .NR_REQ  (NR_REQ),
    .DEPTH   (DEPTH),
    .NR_ROWS (NR_ROWS)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_req_i     (flush_req_i),
    .debug_mode_i    (debug_mode_i),
    .upd_valid_i     (upd_valid_i),
    .upd_ready_o     (upd_ready_o),
    .upd_pc_i        (upd_pc_i),
    .upd_taken_i     (upd_taken_i),
    .bht_upd_valid_o (bht_upd_valid_o),
    .bht_upd_ready_i (bht_upd_ready_i),
    .bht_upd_pc_o    (bht_upd_pc_o),
    .bht_upd_taken_o (bht_upd_taken_o),
    .clr_valid_o     (clr_valid_o),
    .clr_row_o       (clr_row_o),
    .busy_o          (busy_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  int   m_rr     = 0;
  bit   m_flush  = 1'b0;
  int   m_row    = 0;
  int   exp_drop = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input logic [1:0] v, input logic [63:0] p0, input logic [63:0] p1,
                      input logic [1:0] tk, input logic rdy, input logic fl, input logic dbg);
    int          occ;
    logic [1:0]  exp_ready;
    logic        exp_valid;
    upd_valid_i     = v;
    upd_pc_i        = {p1, p0};
    upd_taken_i     = tk;
    bht_upd_ready_i = rdy;
    flush_req_i     = fl;
    debug_mode_i    = dbg;
    @(negedge clk_i);

    check("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop));
    check("busy", 64'(busy_o), 64'(m_flush));
    check("clr_valid", 64'(clr_valid_o), 64'(m_flush));
    if (m_flush) check("clr_row", 64'(clr_row_o), 64'(m_row));

    occ       = sb.size();
    exp_valid = !m_flush && (occ > 0) && !dbg;
    check("bht_valid", 64'(bht_upd_valid_o), 64'(exp_valid));
    if (exp_valid) begin
      check("bht_pc", bht_upd_pc_o, sb[0].pc);
      check("bht_taken", 64'(bht_upd_taken_o), 64'(sb[0].taken));
      if (rdy) void'(sb.pop_front());
    end else if (!m_flush && (occ > 0) && dbg) begin
      void'(sb.pop_front());
      if (exp_drop < 65535) exp_drop++;
    end

    exp_ready = '0;
    if (!m_flush && !fl && occ < DEPTH) begin
      for (int k = 0; k < NR_REQ; k++) begin
        int i;
        i = (m_rr + k) % NR_REQ;
        if (exp_ready == '0 && v[i]) exp_ready[i] = 1'b1;
      end
    end
    check("upd_ready", 64'(upd_ready_o), 64'(exp_ready));
    if (exp_ready[0]) begin sb.push_back('{pc: p0, taken: tk[0]}); m_rr = 1; end
    if (exp_ready[1]) begin sb.push_back('{pc: p1, taken: tk[1]}); m_rr = 0; end

    if (fl) begin
      exp_drop = (exp_drop + sb.size() > 65535) ? 65535 : exp_drop + sb.size();
      sb.delete();
      m_flush = 1'b1;
      m_row   = 0;
    end else if (m_flush) begin
      if (m_row == NR_ROWS - 1) begin m_flush = 1'b0; m_row = 0; end
      else m_row++;
    end

    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, 64'h0, 64'h0, 2'b00, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst_ni          = 1'b0;
    flush_req_i     = 1'b0;
    debug_mode_i    = 1'b0;
    upd_valid_i     = '0;
    upd_pc_i        = '0;
    upd_taken_i     = '0;
    bht_upd_ready_i = 1'b0;
    #12;
    check("rst_bht_valid", 64'(bht_upd_valid_o), 64'h0);
    check("rst_bht_pc", bht_upd_pc_o, 64'h0);
    check("rst_bht_taken", 64'(bht_upd_taken_o), 64'h0);
    check("rst_clr_valid", 64'(clr_valid_o), 64'h0);
    check("rst_clr_row", 64'(clr_row_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_drop", 64'(drop_cnt_o), 64'h0);
    check("rst_upd_ready", 64'(upd_ready_o), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Single push, issued the next cycle, then empty.
    step(2'b01, 64'h1000, 64'h0, 2'b01, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Bring the pointer back to 0, then both requesters for 4 cycles.
    step(2'b10, 64'h0, 64'h2000, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      step(2'b11, 64'h3000 + 64'(k), 64'h4000 + 64'(k), 2'(k), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Predictor stalled: 4 accepted, 5th refused, head held, then drain.
    for (int k = 0; k < 5; k++)
      step(2'b01, 64'h5000 + 64'(k), 64'h0, {1'b0, 1'(k)}, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    for (int k = 0; k < 5; k++) idle(1'b1);

    // Three queued, flush discards them; full 8-row walk; RUN resumes.
    for (int k = 0; k < 3; k++)
      step(2'b01, 64'h6000 + 64'(k), 64'h0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b01, 64'h6100, 64'h0, 2'b01, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NR_ROWS; k++)
      step(2'b01, 64'h6200, 64'h0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b01, 64'h6300, 64'h0, 2'b01, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Restart the walk while row 5 is being cleared.
    step(2'b00, 64'h0, 64'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) idle(1'b0);
    step(2'b00, 64'h0, 64'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < NR_ROWS; k++) idle(1'b0);
    step(2'b01, 64'h7000, 64'h0, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // Debug mode: two queued entries discarded, nothing issued.
    step(2'b01, 64'h8000, 64'h0, 2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b01, 64'h8001, 64'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      step(2'b00, 64'h0, 64'h0, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Reset in the middle of a flush walk at row 3.
    step(2'b00, 64'h0, 64'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0);
    check("pre_rst_row", 64'(clr_row_o), 64'h3);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_clr_valid", 64'(clr_valid_o), 64'h0);
    check("mid_rst_busy", 64'(busy_o), 64'h0);
    check("mid_rst_drop", 64'(drop_cnt_o), 64'h0);
    sb.delete();
    m_rr     = 0;
    m_flush  = 1'b0;
    m_row    = 0;
    exp_drop = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    step(2'b10, 64'h0, 64'h9000, 2'b10, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
